mcbsp_dsp_tx: RTL
=================

MCBSP_DSP_TX -- requirements
Module: mcbsp_dsp_tx

Interface
REQ-001 SHALL provide parameter WORD_LEN, default 32, meaning serial bits per word (legal 8..32).
REQ-002 SHALL provide parameter CLK_DIV, default 1, meaning logic-clock cycles per clkx half-period (legal 1..15).
REQ-003 SHALL provide parameter FRAME_GAP, default 2, meaning idle bit periods after each word (legal 0..7).
REQ-004 mcbsp_clk_in  input  1  logic clock, 10 MHz; all state on rising edge.
REQ-005 mcbsp_rst_in  input  1  asynchronous, active-low reset.
REQ-006 tx_start  input  1  one-cycle pulse; begins a burst of tx_word_num words.
REQ-007 tx_word_num  input  9  words in the burst; sampled on the tx_start cycle.
REQ-008 tx_abort  input  1  level; terminates the burst at the next bit boundary.
REQ-009 tx_data_in  input  32  next word; bits [WORD_LEN-1:0] used; valid the cycle after tx_data_req.
REQ-010 tx_data_req  output  1  one-cycle pulse requesting the next word.
REQ-011 mcbsp_slaver_clkx  output  1  serial bit clock, continuous.
REQ-012 mcbsp_slaver_fsx  output  1  frame sync, active-high, one bit period wide.
REQ-013 mcbsp_slaver_mosi  output  1  serial data, MSB first.
REQ-014 tx_busy  output  1  high from the cycle after accepted tx_start until burst end.
REQ-015 tx_done  output  1  one-cycle pulse at normal burst completion.
REQ-016 debug_signal  output  32  {state[2:0], bit_cnt[5:0], word_cnt[8:0], 14'd0}.

Function
REQ-017 clkx SHALL toggle every CLK_DIV logic cycles, free-running after reset release; bit period = 2*CLK_DIV cycles.
REQ-018 fsx and mosi SHALL change only on the logic-clock edge at which clkx goes 0->1; the receiver samples on clkx falling.
REQ-019 State machine SHALL be IDLE, LOAD, FSYNC, SHIFT, GAP, DONE.
REQ-020 IDLE: fsx=0, mosi=0; tx_start with tx_word_num!=0 -> LOAD, word_cnt=tx_word_num, tx_data_req pulses on that cycle.
REQ-021 tx_start with tx_word_num=0 SHALL produce no frame; tx_done pulses on the cycle after tx_start; tx_busy stays low.
REQ-022 tx_start while tx_busy=1 SHALL be ignored.
REQ-023 LOAD: capture tx_data_in into a shift register on the cycle after tx_data_req, then wait for the next clkx rising boundary -> FSYNC.
REQ-024 FSYNC: fsx=1 and mosi=0 for exactly one bit period (data delay 1) -> SHIFT.
REQ-025 SHIFT: fsx=0; drive bits WORD_LEN-1 down to 0, one per bit period; bit_cnt counts WORD_LEN-1 down to 0.
REQ-026 After bit 0: decrement word_cnt; if FRAME_GAP>0 -> GAP, else go directly to the next-word path.
REQ-027 GAP: fsx=0, mosi=0 for FRAME_GAP bit periods.
REQ-028 Next-word path: word_cnt!=0 -> tx_data_req pulse, then LOAD; word_cnt=0 -> DONE.
REQ-029 Next-word tx_data_req SHALL be issued at least 2 logic cycles before the following FSYNC boundary, so word spacing equals 1+WORD_LEN+FRAME_GAP bit periods, with no extra gap.
REQ-030 DONE: tx_done pulses for one cycle; tx_busy falls on the same cycle; next state is IDLE.
REQ-031 tx_abort sampled high in any non-IDLE state SHALL force IDLE at the next clkx rising boundary: fsx=0, mosi=0, no tx_done, no further tx_data_req.
REQ-032 tx_start and tx_abort asserted in the same cycle in IDLE: tx_abort SHALL win and the start is discarded.

Reset
REQ-033 While mcbsp_rst_in=0, all of the following SHALL hold asynchronously: clkx=0, fsx=0, mosi=0, tx_data_req=0, tx_busy=0, tx_done=0, state=IDLE, counters=0.
REQ-034 Reset asserted mid-burst SHALL abandon the burst with no tx_done; after release, the first frame requires a new tx_start.

Verification
REQ-035 Defaults, tx_word_num=1, data 32'hA5C3_0F81: one fsx pulse 2 cycles wide; mosi MSB-first 1010_0101... over 64 cycles; tx_done once; decoder recovers A5C3_0F81.
REQ-036 tx_word_num=3, data 1,2,3: exactly 3 tx_data_req pulses; fsx rising edges 70 cycles apart; words received in order; single tx_done.
REQ-037 tx_word_num=0: no fsx and no tx_data_req; tx_done the cycle after tx_start.
REQ-038 tx_abort raised mid-SHIFT of word 2 of 4: fsx and mosi low by the next clkx rise; no tx_done; tx_busy low; a new tx_start then works.
REQ-039 Reset pulsed low during FSYNC: all outputs 0 immediately; no activity until the next tx_start.
REQ-040 WORD_LEN=16, CLK_DIV=2, FRAME_GAP=0, 2 words: 4-cycle bit period; fsx rising edges 68 cycles apart; tx_start while busy ignored.

Source files
------------

// File: rtl/mcbsp_dsp_tx.sv
// McBSP-style burst transmitter: free-running bit clock, one-bit-wide frame sync,
// MSB-first data with one bit of data delay and a programmable inter-word gap.
module mcbsp_dsp_tx #(
    parameter int WORD_LEN  = 32,
    parameter int CLK_DIV   = 1,
    parameter int FRAME_GAP = 2
) (
    input  logic        mcbsp_clk_in,
    input  logic        mcbsp_rst_in,
    input  logic        tx_start,
    input  logic [8:0]  tx_word_num,
    input  logic        tx_abort,
    input  logic [31:0] tx_data_in,
    output logic        tx_data_req,
    output logic        mcbsp_slaver_clkx,
    output logic        mcbsp_slaver_fsx,
    output logic        mcbsp_slaver_mosi,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [31:0] debug_signal
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FSYNC = 3'd2,
        SHIFT = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          div_cnt_reg, div_cnt_next;
    logic                clkx_reg, clkx_next;
    logic                fsx_reg, fsx_next;
    logic                mosi_reg, mosi_next;
    logic                req_reg, req_next;
    logic                req_d_reg;
    logic                abort_pend_reg, abort_pend_next;
    logic [WORD_LEN-1:0] shift_reg, shift_next;
    logic [5:0]          bit_cnt_reg, bit_cnt_next;
    logic [8:0]          word_cnt_reg, word_cnt_next;
    logic [2:0]          gap_cnt_reg, gap_cnt_next;

    logic div_tick;
    logic rise_tick;
    logic abort_now;
    logic more_words;
    logic last_period;
    logic unused_data_bits;

    assign unused_data_bits = ^tx_data_in;

    assign div_tick  = (div_cnt_reg == 4'(CLK_DIV - 1));
    assign rise_tick = div_tick && !clkx_reg;
    assign abort_now = tx_abort || abort_pend_reg;

    // In GAP the finished word has already been subtracted from word_cnt.
    assign more_words = (state_reg == GAP) ? (word_cnt_reg != 9'd0) : (word_cnt_reg > 9'd1);

    // True on the boundary that opens the final bit period before the next
    // frame sync; the next word is fetched then so words stay back-to-back.
    assign last_period = ((state_reg == SHIFT) && (bit_cnt_reg == 6'd1) && (FRAME_GAP == 0)) ||
                         ((state_reg == SHIFT) && (bit_cnt_reg == 6'd0) && (FRAME_GAP == 1)) ||
                         ((state_reg == GAP)   && (gap_cnt_reg == 3'd1));

    always_ff @(posedge mcbsp_clk_in or negedge mcbsp_rst_in) begin
        if (!mcbsp_rst_in) begin
            state_reg      <= IDLE;
            div_cnt_reg    <= '0;
            clkx_reg       <= 1'b0;
            fsx_reg        <= 1'b0;
            mosi_reg       <= 1'b0;
            req_reg        <= 1'b0;
            req_d_reg      <= 1'b0;
            abort_pend_reg <= 1'b0;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            word_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            div_cnt_reg    <= div_cnt_next;
            clkx_reg       <= clkx_next;
            fsx_reg        <= fsx_next;
            mosi_reg       <= mosi_next;
            req_reg        <= req_next;
            req_d_reg      <= req_reg;
            abort_pend_reg <= abort_pend_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            word_cnt_reg   <= word_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        div_cnt_next    = div_cnt_reg + 4'd1;
        clkx_next       = clkx_reg;
        fsx_next        = fsx_reg;
        mosi_next       = mosi_reg;
        req_next        = 1'b0;
        abort_pend_next = abort_pend_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        word_cnt_next   = word_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;

        if (div_tick) begin
            div_cnt_next = '0;
            clkx_next    = ~clkx_reg;
        end

        // Data arrives the cycle after the request; shifting never coincides.
        if (req_d_reg) begin
            shift_next = tx_data_in[WORD_LEN-1:0];
        end

        case (state_reg)
            IDLE: begin
                abort_pend_next = 1'b0;
                fsx_next        = 1'b0;
                mosi_next       = 1'b0;
                if (tx_start && !tx_abort) begin
                    if (tx_word_num != 9'd0) begin
                        state_next    = LOAD;
                        word_cnt_next = tx_word_num;
                        req_next      = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                if (tx_abort) begin
                    abort_pend_next = 1'b1;
                end
                if (rise_tick) begin
                    if (abort_now) begin
                        state_next      = IDLE;
                        fsx_next        = 1'b0;
                        mosi_next       = 1'b0;
                        bit_cnt_next    = '0;
                        word_cnt_next   = '0;
                        gap_cnt_next    = '0;
                        abort_pend_next = 1'b0;
                    end else begin
                        if (last_period && more_words) begin
                            req_next = 1'b1;
                        end
                        case (state_reg)
                            LOAD: begin
                                if (!req_reg) begin
                                    state_next = FSYNC;
                                    fsx_next   = 1'b1;
                                    mosi_next  = 1'b0;
                                end
                            end
                            FSYNC: begin
                                state_next   = SHIFT;
                                fsx_next     = 1'b0;
                                mosi_next    = shift_reg[WORD_LEN-1];
                                shift_next   = shift_reg << 1;
                                bit_cnt_next = 6'(WORD_LEN - 1);
                            end
                            SHIFT: begin
                                if (bit_cnt_reg != 6'd0) begin
                                    mosi_next    = shift_reg[WORD_LEN-1];
                                    shift_next   = shift_reg << 1;
                                    bit_cnt_next = bit_cnt_reg - 6'd1;
                                end else begin
                                    word_cnt_next = word_cnt_reg - 9'd1;
                                    mosi_next     = 1'b0;
                                    if (FRAME_GAP > 0) begin
                                        state_next   = GAP;
                                        gap_cnt_next = 3'(FRAME_GAP - 1);
                                    end else if (word_cnt_reg > 9'd1) begin
                                        state_next = FSYNC;
                                        fsx_next   = 1'b1;
                                    end else begin
                                        state_next = DONE;
                                    end
                                end
                            end
                            GAP: begin
                                if (gap_cnt_reg != 3'd0) begin
                                    gap_cnt_next = gap_cnt_reg - 3'd1;
                                end else if (word_cnt_reg != 9'd0) begin
                                    state_next = FSYNC;
                                    fsx_next   = 1'b1;
                                end else begin
                                    state_next = DONE;
                                end
                            end
                            default: begin
                                state_next = IDLE;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    assign tx_data_req       = req_reg;
    assign mcbsp_slaver_clkx = clkx_reg;
    assign mcbsp_slaver_fsx  = fsx_reg;
    assign mcbsp_slaver_mosi = mosi_reg;
    assign tx_busy           = (state_reg == LOAD) || (state_reg == FSYNC) ||
                               (state_reg == SHIFT) || (state_reg == GAP);
    assign tx_done           = (state_reg == DONE);
    assign debug_signal      = {state_reg, bit_cnt_reg, word_cnt_reg, 14'd0};

endmodule
